hazard_ctrl: RTL and testbench

- Central hazard and forwarding controller for the 5-stage pipeline: IF, ID, EX, MEM, WB.
- Generates forwarding selects for the EX operands.
- Detects load-use hazards and inserts a one-cycle bubble.
- Flushes wrong-path instructions on a branch or jump redirect resolved in EX.
- Freezes the pipeline for multi-cycle data-memory accesses (parametrised latency).
- Provides saturating stall and flush performance counters.
- Instantiated in the top level beside the pipeline registers, which take its stall, flush and bubble outputs.

---
 rtl/hazard_pkg.sv | 10 +
 rtl/hazard_ctrl_sat_counter.sv | 18 +
 rtl/hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_hazard_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard/forwarding controller.
package hazard_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_state_e;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: EX operand forwarding, load-use bubble, redirect flush,
// multi-cycle data-memory freeze and stall/flush performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_wreg,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic              ex_redirect,
  input  logic [REG_AW-1:0] mem_wreg,
  input  logic              mem_regwrite,
  input  logic              mem_memread,
  input  logic              mem_memwrite,
  input  logic [REG_AW-1:0] wb_wreg,
  input  logic              wb_regwrite,
  input  logic              perf_clr,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              idex_bubble,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              freeze,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Latency is at most 16, so the wait count never exceeds 13.
  localparam logic [3:0] WAIT_INIT = 4'((MEM_LAT > 2) ? MEM_LAT - 3 : 0);

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic              m_we,
    input logic [REG_AW-1:0] m_wr,
    input logic              w_we,
    input logic [REG_AW-1:0] w_wr
  );
    if (m_we && m_wr != '0 && m_wr == src)      return FWD_EXMEM;
    else if (w_we && w_wr != '0 && w_wr == src) return FWD_MEMWB;
    else                                        return FWD_RF;
  endfunction

  logic       load_use, mem_access, frz;
  mem_state_e state, state_nx;
  logic [3:0] wcnt, wcnt_nx;

  // A load in EX always writes a register, so ex_regwrite adds nothing here.
  logic unused_ex_regwrite;
  assign unused_ex_regwrite = ex_regwrite;

  assign fwd_a = fwd_sel(ex_rs, mem_regwrite, mem_wreg, wb_regwrite, wb_wreg);
  assign fwd_b = fwd_sel(ex_rt, mem_regwrite, mem_wreg, wb_regwrite, wb_wreg);

  assign load_use   = ex_memread && ex_wreg != '0 &&
                      ((id_uses_rs && ex_wreg == id_rs) || (id_uses_rt && ex_wreg == id_rt));
  assign mem_access = mem_memread || mem_memwrite;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    frz      = 1'b0;
    case (state)
      IDLE: if (mem_access && MEM_LAT > 1) begin
        frz = 1'b1;
        if (MEM_LAT == 2) state_nx = DONE;
        else begin
          state_nx = WAIT;
          wcnt_nx  = WAIT_INIT;
        end
      end
      WAIT: begin
        frz = 1'b1;
        if (wcnt == '0) state_nx = DONE;
        else            wcnt_nx  = wcnt - 1'b1;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // IDLE raises freeze combinationally, so mask it while reset is held.
  assign freeze = frz & rst_n;

  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    if (freeze) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
    end else if (ex_redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .inc(pc_stall), .clr(perf_clr), .cnt(stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .inc(ifid_flush), .clr(perf_clr), .cnt(flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (MEM_LAT=4/CNT_W=32 and MEM_LAT=1/CNT_W=4)
// checked every cycle against a behavioural model plus directed literal checks.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_wreg, mem_wreg, wb_wreg;
  logic id_uses_rs, id_uses_rt, ex_regwrite, ex_memread, ex_redirect;
  logic mem_regwrite, mem_memread, mem_memwrite, wb_regwrite, perf_clr;

  logic [1:0]  a_fwd_a, a_fwd_b, b_fwd_a, b_fwd_b;
  logic        a_pc_stall, a_ifid_stall, a_idex_bubble, a_ifid_flush, a_idex_flush, a_freeze;
  logic        b_pc_stall, b_ifid_stall, b_idex_bubble, b_ifid_flush, b_idex_flush, b_freeze;
  logic [31:0] a_stall_cnt, a_flush_cnt;
  logic [3:0]  b_stall_cnt, b_flush_cnt;

  hazard_ctrl #(.REG_AW(5), .MEM_LAT(4), .CNT_W(32)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_wreg(ex_wreg), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_redirect(ex_redirect), .mem_wreg(mem_wreg), .mem_regwrite(mem_regwrite),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .wb_wreg(wb_wreg),
    .wb_regwrite(wb_regwrite), .perf_clr(perf_clr), .fwd_a(a_fwd_a), .fwd_b(a_fwd_b),
    .pc_stall(a_pc_stall), .ifid_stall(a_ifid_stall), .idex_bubble(a_idex_bubble),
    .ifid_flush(a_ifid_flush), .idex_flush(a_idex_flush), .freeze(a_freeze),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  hazard_ctrl #(.REG_AW(5), .MEM_LAT(1), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_wreg(ex_wreg), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_redirect(ex_redirect), .mem_wreg(mem_wreg), .mem_regwrite(mem_regwrite),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .wb_wreg(wb_wreg),
    .wb_regwrite(wb_regwrite), .perf_clr(perf_clr), .fwd_a(b_fwd_a), .fwd_b(b_fwd_b),
    .pc_stall(b_pc_stall), .ifid_stall(b_ifid_stall), .idex_bubble(b_idex_bubble),
    .ifid_flush(b_ifid_flush), .idex_flush(b_idex_flush), .freeze(b_freeze),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    {id_rs, id_rt, ex_rs, ex_rt, ex_wreg, mem_wreg, wb_wreg} = '0;
    {id_uses_rs, id_uses_rt, ex_regwrite, ex_memread, ex_redirect} = '0;
    {mem_regwrite, mem_memread, mem_memwrite, wb_regwrite, perf_clr} = '0;
  endtask

  task automatic set_load_use();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd5;
    id_rt = 5'd5; id_uses_rt = 1'b1;
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (mem_regwrite && mem_wreg != 0 && mem_wreg == src) return 2'b10;
    if (wb_regwrite && wb_wreg != 0 && wb_wreg == src)    return 2'b01;
    return 2'b00;
  endfunction

  // k = cycles since the current access began, -1 when no access is in flight.
  // Freeze covers the first lat-1 cycles; cycle lat-1 is the completing cycle.
  function automatic bit m_frz(input int k, input int lat, input bit acc);
    bit act;
    act = (k >= 0) || (acc && lat > 1);
    return act && ((k >= 0 ? k : 0) < lat - 1);
  endfunction

  function automatic int m_knext(input int k, input int lat, input bit acc);
    int kk;
    if (!((k >= 0) || (acc && lat > 1))) return -1;
    kk = (k >= 0) ? k : 0;
    return (kk == lat - 1) ? -1 : kk + 1;
  endfunction

  int     k_a = -1, k_b = -1;
  longint s_a = 0, f_a = 0;
  int     s_b = 0, f_b = 0;

  always @(negedge clk) begin
    bit acc, lu, fz, pcs, fl, bub;
    logic [1:0] fa, fb;
    if (!rst_n) begin
      k_a = -1; k_b = -1; s_a = 0; f_a = 0; s_b = 0; f_b = 0;
    end
    acc = mem_memread || mem_memwrite;
    lu  = ex_memread && ex_wreg != 0 &&
          ((id_uses_rs && ex_wreg == id_rs) || (id_uses_rt && ex_wreg == id_rt));
    fa  = m_fwd(ex_rs);
    fb  = m_fwd(ex_rt);

    fz  = rst_n && m_frz(k_a, 4, acc);
    pcs = fz || (!ex_redirect && lu);
    fl  = !fz && ex_redirect;
    bub = !fz && !ex_redirect && lu;
    chk("a_outputs", {a_fwd_a, a_fwd_b, a_pc_stall, a_ifid_stall, a_idex_bubble,
                      a_ifid_flush, a_idex_flush, a_freeze},
                     {fa, fb, pcs, pcs, bub, fl, fl, fz});
    chk("a_stall_cnt", a_stall_cnt, 32'(s_a));
    chk("a_flush_cnt", a_flush_cnt, 32'(f_a));
    if (rst_n) begin
      s_a = perf_clr ? 0 : (pcs && s_a < 64'hFFFF_FFFF) ? s_a + 1 : s_a;
      f_a = perf_clr ? 0 : (fl  && f_a < 64'hFFFF_FFFF) ? f_a + 1 : f_a;
      k_a = m_knext(k_a, 4, acc);
    end

    fz  = rst_n && m_frz(k_b, 1, acc);
    pcs = fz || (!ex_redirect && lu);
    fl  = !fz && ex_redirect;
    bub = !fz && !ex_redirect && lu;
    chk("b_outputs", {b_fwd_a, b_fwd_b, b_pc_stall, b_ifid_stall, b_idex_bubble,
                      b_ifid_flush, b_idex_flush, b_freeze},
                     {fa, fb, pcs, pcs, bub, fl, fl, fz});
    chk("b_stall_cnt", 32'(b_stall_cnt), 32'(s_b));
    chk("b_flush_cnt", 32'(b_flush_cnt), 32'(f_b));
    if (rst_n) begin
      s_b = perf_clr ? 0 : (pcs && s_b < 15) ? s_b + 1 : s_b;
      f_b = perf_clr ? 0 : (fl  && f_b < 15) ? f_b + 1 : f_b;
      k_b = m_knext(k_b, 1, acc);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] fr4;
    logic [7:0] fr8;
    clr_in();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_freeze", 32'(a_freeze), 32'd0);
    chk("rst_stall_cnt", a_stall_cnt, 32'd0);
    chk("rst_flush_cnt", a_flush_cnt, 32'd0);
    rst_n = 1'b1;

    // forwarding
    step();
    mem_regwrite = 1'b1; mem_wreg = 5'd3; ex_rs = 5'd3;
    #1 chk("fwd_exmem", 32'(a_fwd_a), 32'(FWD_EXMEM));
    wb_regwrite = 1'b1; wb_wreg = 5'd3;
    #1 chk("fwd_exmem_prio", 32'(a_fwd_a), 32'b10);
    mem_regwrite = 1'b0;
    #1 chk("fwd_memwb", 32'(a_fwd_a), 32'b01);
    mem_regwrite = 1'b1; mem_wreg = 5'd0; ex_rs = 5'd0; ex_rt = 5'd3;
    #1 chk("fwd_r0", 32'(a_fwd_a), 32'b00);
    chk("fwd_b_memwb", 32'(a_fwd_b), 32'b01);

    // load-use: one-cycle bubble
    step(); clr_in(); perf_clr = 1'b1;
    step(); perf_clr = 1'b0; set_load_use();
    #1 chk("lu_stall", 32'({a_pc_stall, a_ifid_stall, a_idex_bubble}), 32'b111);
    step(); ex_memread = 1'b0; ex_wreg = 5'd0; mem_regwrite = 1'b1; mem_wreg = 5'd5;
    #1 chk("lu_clear", 32'({a_pc_stall, a_ifid_stall, a_idex_bubble}), 32'b000);
    chk("lu_stall_cnt", a_stall_cnt, 32'd1);

    // redirect beats load-use
    step(); clr_in(); perf_clr = 1'b1;
    step(); perf_clr = 1'b0; set_load_use(); ex_redirect = 1'b1;
    #1 chk("redir", 32'({a_ifid_flush, a_idex_flush, a_pc_stall, a_idex_bubble}), 32'b1100);
    step(); clr_in();
    #1 chk("redir_flush_cnt", a_flush_cnt, 32'd1);
    chk("redir_stall_cnt", a_stall_cnt, 32'd0);

    // single lw, MEM_LAT=4
    step(); perf_clr = 1'b1;
    step(); perf_clr = 1'b0; mem_memread = 1'b1; mem_regwrite = 1'b1; mem_wreg = 5'd8;
    for (int i = 0; i < 4; i++) begin
      #1 fr4[3-i] = a_freeze;
      step();
    end
    mem_memread = 1'b0;
    #1 chk("lw_freeze_seq", 32'(fr4), 32'b1110);
    chk("lw_stall_cnt", a_stall_cnt, 32'd3);

    // sw then lw back to back
    for (int i = 0; i < 8; i++) begin
      mem_memwrite = (i < 4); mem_memread = (i >= 4);
      #1 fr8[7-i] = a_freeze;
      step();
    end
    mem_memread = 1'b0; mem_memwrite = 1'b0;
    #1 chk("b2b_freeze_seq", 32'(fr8), 32'b1110_1110);

    // reset during the second freeze cycle
    step(); mem_memread = 1'b1;
    step();
    #1 chk("mid_frz_pre", 32'(a_freeze), 32'd1);
    rst_n = 1'b0;
    #1 chk("mid_frz_rst", 32'(a_freeze), 32'd0);
    chk("mid_frz_stall_cnt", a_stall_cnt, 32'd0);
    chk("mid_frz_flush_cnt", a_flush_cnt, 32'd0);
    step(); rst_n = 1'b1; mem_memread = 1'b0;

    // perf_clr with stall_cnt = 7
    step(); set_load_use();
    repeat (7) step();
    chk("clr_pre7", a_stall_cnt, 32'd7);
    perf_clr = 1'b1;
    step(); perf_clr = 1'b0; clr_in();
    #1 chk("clr_to0", a_stall_cnt, 32'd0);

    // 4-bit counter saturates
    set_load_use();
    repeat (20) step();
    chk("sat4_stall", 32'(b_stall_cnt), 32'd15);
    chk("wide_stall", a_stall_cnt, 32'd20);
    clr_in();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      step();
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
      ex_wreg = 5'($urandom_range(0, 3)); mem_wreg = 5'($urandom_range(0, 3));
      wb_wreg = 5'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom_range(0, 1)); id_uses_rt = 1'($urandom_range(0, 1));
      ex_regwrite = 1'($urandom_range(0, 1)); ex_memread = ($urandom_range(0, 3) == 0);
      ex_redirect = ($urandom_range(0, 7) == 0);
      mem_regwrite = 1'($urandom_range(0, 1)); wb_regwrite = 1'($urandom_range(0, 1));
      mem_memread = ($urandom_range(0, 4) == 0); mem_memwrite = ($urandom_range(0, 9) == 0);
      perf_clr = ($urandom_range(0, 31) == 0);
      rst_n = ($urandom_range(0, 99) != 0);
    end
    step(); rst_n = 1'b1; clr_in();
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
